param_sync_fifo: RTL and testbench

Parametrised single-clock FIFO; next-generation replacement for the team's fixed 4×16 buffer. Adds configurable width and depth, concurrent read and write in one cycle, wrap-safe full detection, an occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. Sits between a producer and a consumer in the same clock domain as a general-purpose elastic buffer.

---
 rtl/param_sync_fifo.sv | 133 +++++++++++++
 tb/tb_param_sync_fifo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags. Registered read data, no bypass.
module param_sync_fifo #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 2,
  parameter int AFULL_TH  = 3,
  parameter int AEMPTY_TH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              empty_s, full_s;
  logic              wr_acc_s, rd_acc_s;

  // Full/empty come from the registered count only, so accept decisions never
  // see the current cycle's requests.
  assign empty_s  = (count_q == {PTR_W{1'b0}});
  assign full_s   = (count_q == PTR_W'(DEPTH));
  assign wr_acc_s = wr_en & ~full_s;
  assign rd_acc_s = rd_en & ~empty_s;

  // Next-state for pointers, count, read data and error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_acc_s) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      rd_data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
      rd_valid_d = 1'b1;
    end else begin
      rd_ptr_d   = rd_ptr_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
    end

    // Modulo subtraction; wrap bit separates full from empty.
    count_d = wr_ptr_d - rd_ptr_d;

    // A coincident error event beats the clear.
    if (wr_en & full_s) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    if (rd_en & empty_s) begin
      underflow_d = 1'b1;
    end else if (clr_err) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // Control and status registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {PTR_W{1'b0}};
      rd_data_q   <= {DATA_W{1'b0}};
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign empty        = empty_s;
  assign full         = full_s;
  assign almost_empty = (count_q <= PTR_W'(AEMPTY_TH));
  assign almost_full  = (count_q >= PTR_W'(AFULL_TH));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo at default parameters
// (DEPTH 4, almost_full at 3, almost_empty at 1).
module tb_param_sync_fifo;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        rd_en;
  logic        clr_err;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [2:0]  count;
  logic        empty;
  logic        full;
  logic        almost_empty;
  logic        almost_full;
  logic        overflow;
  logic        underflow;

  int passes = 0;
  int checks = 0;

  param_sync_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Flags packed as {empty, full, almost_empty, almost_full, overflow, underflow}.
  task automatic chk_st(input string tag, input logic [2:0] exp_cnt, input logic [5:0] exp_flags);
    chk({tag, ".count"}, {29'd0, count}, {29'd0, exp_cnt});
    chk({tag, ".flags"}, {26'd0, empty, full, almost_empty, almost_full, overflow, underflow},
        {26'd0, exp_flags});
  endtask

  task automatic chk_rd(input string tag, input logic exp_valid, input logic [15:0] exp_data);
    chk({tag, ".rd_valid"}, {31'd0, rd_valid}, {31'd0, exp_valid});
    chk({tag, ".rd_data"}, {16'd0, rd_data}, {16'd0, exp_data});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [15:0] d, input logic r, input logic c);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr_err = c;
  endtask

  initial begin
    logic [15:0] exp_q [$];
    logic [15:0] exp_word;

    rst = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_st("reset_idle", 3'd0, 6'b101000);
    chk_rd("reset_idle", 1'b0, 16'h0000);

    // Fill to full, then one rejected write.
    drive(1'b1, 16'h1111, 1'b0, 1'b0); tick(); chk_st("fill1", 3'd1, 6'b001000);
    drive(1'b1, 16'h2222, 1'b0, 1'b0); tick(); chk_st("fill2", 3'd2, 6'b000000);
    drive(1'b1, 16'h3333, 1'b0, 1'b0); tick(); chk_st("fill3", 3'd3, 6'b000100);
    drive(1'b1, 16'h4444, 1'b0, 1'b0); tick(); chk_st("fill4", 3'd4, 6'b010100);
    drive(1'b1, 16'h5555, 1'b0, 1'b0); tick(); chk_st("ovf_write", 3'd4, 6'b010110);
    chk_rd("ovf_write", 1'b0, 16'h0000);

    // Drain in order; overflow stays sticky.
    drive(1'b0, 16'h0000, 1'b1, 1'b0); tick();
    chk_rd("drain1", 1'b1, 16'h1111); chk_st("drain1", 3'd3, 6'b000110);
    tick(); chk_rd("drain2", 1'b1, 16'h2222); chk_st("drain2", 3'd2, 6'b000010);
    tick(); chk_rd("drain3", 1'b1, 16'h3333); chk_st("drain3", 3'd1, 6'b001010);
    tick(); chk_rd("drain4", 1'b1, 16'h4444); chk_st("drain4", 3'd0, 6'b101010);
    tick(); chk_rd("udf_read", 1'b0, 16'h4444); chk_st("udf_read", 3'd0, 6'b101011);
    drive(1'b0, 16'h0000, 1'b0, 1'b1); tick();
    chk_st("clr_err", 3'd0, 6'b101000);

    // Concurrent traffic across pointer wrap.
    drive(1'b1, 16'h0101, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0202, 1'b0, 1'b0); tick();
    chk_st("preload", 3'd2, 6'b000000);
    exp_q.push_back(16'h0101);
    exp_q.push_back(16'h0202);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'hA000 + 16'(i), 1'b1, 1'b0);
      exp_q.push_back(16'hA000 + 16'(i));
      tick();
      exp_word = exp_q.pop_front();
      chk_rd($sformatf("concur%0d", i), 1'b1, exp_word);
      chk_st($sformatf("concur%0d", i), 3'd2, 6'b000000);
    end

    // Top up to full (A008, A009, B001, B002), then write+read at full.
    drive(1'b1, 16'hB001, 1'b0, 1'b0); tick();
    drive(1'b1, 16'hB002, 1'b0, 1'b0); tick();
    chk_st("refill", 3'd4, 6'b010100);
    drive(1'b1, 16'hC0DE, 1'b1, 1'b0); tick();
    chk_rd("full_wr_rd", 1'b1, 16'hA008); chk_st("full_wr_rd", 3'd3, 6'b000110);
    drive(1'b0, 16'h0000, 1'b1, 1'b0); tick(); chk_rd("post_full1", 1'b1, 16'hA009);
    tick(); chk_rd("post_full2", 1'b1, 16'hB001);
    tick(); chk_rd("post_full3", 1'b1, 16'hB002); chk_st("post_full3", 3'd0, 6'b101010);
    drive(1'b0, 16'h0000, 1'b0, 1'b1); tick();
    chk_st("clr_err2", 3'd0, 6'b101000);

    // Write+read at empty: write only, no bypass.
    drive(1'b1, 16'hBEEF, 1'b1, 1'b0); tick();
    chk_rd("empty_wr_rd", 1'b0, 16'hB002); chk_st("empty_wr_rd", 3'd1, 6'b001001);
    drive(1'b0, 16'h0000, 1'b1, 1'b0); tick();
    chk_rd("beef_read", 1'b1, 16'hBEEF); chk_st("beef_read", 3'd0, 6'b101001);

    // Reset in the middle of traffic, asserted between edges.
    drive(1'b1, 16'h1234, 1'b0, 1'b1); tick();
    drive(1'b1, 16'h5678, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h9ABC, 1'b1, 1'b0); tick();
    drive(1'b1, 16'hDEF0, 1'b0, 1'b0); tick();
    chk_st("pre_rst", 3'd3, 6'b000100);
    chk_rd("pre_rst", 1'b0, 16'h1234);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_st("async_rst", 3'd0, 6'b101000);
    chk_rd("async_rst", 1'b0, 16'h0000);
    tick();
    rst = 1'b0;
    drive(1'b1, 16'h5050, 1'b0, 1'b0); tick();
    chk_st("post_rst_wr", 3'd1, 6'b001000);
    drive(1'b0, 16'h0000, 1'b1, 1'b0); tick();
    chk_rd("post_rst_rd", 1'b1, 16'h5050);
    chk_st("post_rst_rd", 3'd0, 6'b101000);

    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
